// File: rtl/qupls_rename_pkg.sv
// Shared types and sizes for the register rename stage.
// Optional feature macro: QUPLS_RENAME_PERF_EN (see qupls_rename_stage).
package qupls_rename_pkg;

    localparam int AREGS    = 64;
    localparam int PREGS    = 128;
    localparam int FL_DEPTH = PREGS - AREGS;
    localparam int AW       = $clog2(AREGS);
    localparam int PW       = $clog2(PREGS);
    localparam int FW       = $clog2(FL_DEPTH);

    typedef logic [8:0]    aregno_t;
    typedef logic [PW-1:0] pregno_t;
    typedef logic [AW-1:0] aidx_t;
    typedef logic [FW:0]   flptr_t;

    typedef struct packed {
        pregno_t pRa;
        pregno_t pRb;
        pregno_t pRc;
        pregno_t pRt;
        pregno_t pRtOld;
        aregno_t aRt;
        logic    has_dst;
    } rename_out_t;

endpackage

// File: rtl/qupls_rename_if.sv
// Decode-in / rename-out handshake plus commit and flush.
// master drives instructions and commits, slave is the rename stage.
interface qupls_rename_if;
    import qupls_rename_pkg::*;

    logic    in_v;
    logic    in_rdy;
    aregno_t in_aRa;
    aregno_t in_aRb;
    aregno_t in_aRc;
    aregno_t in_aRt;
    logic    in_Raz;
    logic    in_Rbz;
    logic    in_Rcz;
    logic    in_Rtz;

    logic    out_v;
    logic    out_rdy;
    pregno_t out_pRa;
    pregno_t out_pRb;
    pregno_t out_pRc;
    pregno_t out_pRt;
    pregno_t out_pRtOld;
    aregno_t out_aRt;
    logic    out_has_dst;

    logic    cmt_v;
    logic    cmt_has_dst;
    aregno_t cmt_aRt;
    pregno_t cmt_pRt;
    pregno_t cmt_pRtOld;
    logic    flush;

    modport master (
        output in_v, in_aRa, in_aRb, in_aRc, in_aRt,
        output in_Raz, in_Rbz, in_Rcz, in_Rtz,
        input  in_rdy,
        input  out_v, out_pRa, out_pRb, out_pRc,
        input  out_pRt, out_pRtOld, out_aRt, out_has_dst,
        output out_rdy,
        output cmt_v, cmt_has_dst, cmt_aRt, cmt_pRt, cmt_pRtOld,
        output flush
    );

    modport slave (
        input  in_v, in_aRa, in_aRb, in_aRc, in_aRt,
        input  in_Raz, in_Rbz, in_Rcz, in_Rtz,
        output in_rdy,
        output out_v, out_pRa, out_pRb, out_pRc,
        output out_pRt, out_pRtOld, out_aRt, out_has_dst,
        input  out_rdy,
        input  cmt_v, cmt_has_dst, cmt_aRt, cmt_pRt, cmt_pRtOld,
        input  flush
    );

endinterface

// File: rtl/qupls_rename_freelist.sv
// Circular physical-register free list with speculative alloc head,
// committed head and tail; flush rewinds alloc head to the committed head.
module qupls_rename_freelist
    import qupls_rename_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    pop,
    input  logic    push,
    input  pregno_t push_preg,
    input  logic    cmt_adv,
    input  logic    flush,
    output pregno_t alloc_preg,
    output flptr_t  count
);

    pregno_t mem [FL_DEPTH];
    flptr_t  alloc_head;
    flptr_t  commit_head;
    flptr_t  tail;
    logic    full;
    logic    do_push;

    assign count      = tail - alloc_head;
    assign full       = count == flptr_t'(FL_DEPTH);
    assign do_push    = push & ~full;
    assign alloc_preg = mem[alloc_head[FW-1:0]];

    // Storage: preload the non-architectural registers, append freed ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++)
                mem[i] <= pregno_t'(AREGS + i);
        end else if (do_push) begin
            mem[tail[FW-1:0]] <= push_preg;
        end
    end

    // Pointers: a same-cycle commit counts toward the flush restore point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_head  <= '0;
            commit_head <= '0;
            tail        <= flptr_t'(FL_DEPTH);
        end else begin
            if (do_push)
                tail <= tail + 1'b1;
            if (cmt_adv)
                commit_head <= commit_head + 1'b1;
            if (flush)
                alloc_head <= commit_head + flptr_t'(cmt_adv);
            else if (pop)
                alloc_head <= alloc_head + 1'b1;
        end
    end

`ifndef SYNTHESIS
    // A push into a full list means a register was freed twice
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && full)
    );
`endif

endmodule

// File: rtl/qupls_rename_stage.sv
// Register rename: speculative and committed RATs plus free list.
// Define QUPLS_RENAME_PERF_EN to add the stall_cnt empty-list counter.
module qupls_rename_stage
    import qupls_rename_pkg::*;
(
    input  logic clk,
    input  logic rst,
    qupls_rename_if.slave rn
`ifdef QUPLS_RENAME_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    pregno_t     spec_rat [AREGS];
    pregno_t     cmt_rat  [AREGS];
    rename_out_t out_q;
    rename_out_t out_d;
    logic        out_v_q;
    pregno_t     fl_preg;
    flptr_t      fl_count;
    logic        fl_empty;
    logic        dst;
    logic        accept;
    logic        alloc;
    logic        cmt_we;
    logic        cmt_free;
    aidx_t       ra, rb, rc, ta, ca;
    logic        unused_hi;

    assign ra = rn.in_aRa[AW-1:0];
    assign rb = rn.in_aRb[AW-1:0];
    assign rc = rn.in_aRc[AW-1:0];
    assign ta = rn.in_aRt[AW-1:0];
    assign ca = rn.cmt_aRt[AW-1:0];

    assign unused_hi = ^{rn.in_aRa[8:AW], rn.in_aRb[8:AW],
                         rn.in_aRc[8:AW], rn.cmt_aRt[8:AW]};

    assign dst      = ~rn.in_Rtz;
    assign fl_empty = fl_count == '0;
    assign rn.in_rdy = ~rst & ~rn.flush
                     & (~out_v_q | rn.out_rdy)
                     & ~(dst & fl_empty);
    assign accept   = rn.in_v & rn.in_rdy;
    assign alloc    = accept & dst;
    assign cmt_we   = rn.cmt_v & rn.cmt_has_dst;
    assign cmt_free = cmt_we & (rn.cmt_pRtOld != '0);

    qupls_rename_freelist u_fl (
        .clk        (clk),
        .rst        (rst),
        .pop        (alloc),
        .push       (cmt_free),
        .push_preg  (rn.cmt_pRtOld),
        .cmt_adv    (cmt_we),
        .flush      (rn.flush),
        .alloc_preg (fl_preg),
        .count      (fl_count)
    );

    // Rename from the map as it stands before this edge's write
    always_comb begin
        out_d         = '0;
        out_d.pRa     = rn.in_Raz ? '0 : spec_rat[ra];
        out_d.pRb     = rn.in_Rbz ? '0 : spec_rat[rb];
        out_d.pRc     = rn.in_Rcz ? '0 : spec_rat[rc];
        out_d.aRt     = rn.in_aRt;
        out_d.has_dst = dst;
        if (dst) begin
            out_d.pRt    = fl_preg;
            out_d.pRtOld = spec_rat[ta];
        end
    end

    // Output register: load on accept, drain when taken, kill on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            out_v_q <= 1'b0;
        end else if (rn.flush) begin
            out_v_q <= 1'b0;
        end else if (accept) begin
            out_q   <= out_d;
            out_v_q <= 1'b1;
        end else if (rn.out_rdy) begin
            out_v_q <= 1'b0;
        end
    end

    // Speculative map: reload from committed map on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AREGS; i++)
                spec_rat[i] <= pregno_t'(i);
        end else if (rn.flush) begin
            for (int i = 0; i < AREGS; i++)
                spec_rat[i] <= (cmt_we && ca == aidx_t'(i))
                             ? rn.cmt_pRt : cmt_rat[i];
        end else if (alloc) begin
            spec_rat[ta] <= fl_preg;
        end
    end

    // Committed map follows retirement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AREGS; i++)
                cmt_rat[i] <= pregno_t'(i);
        end else if (cmt_we) begin
            cmt_rat[ca] <= rn.cmt_pRt;
        end
    end

    assign rn.out_v       = out_v_q;
    assign rn.out_pRa     = out_q.pRa;
    assign rn.out_pRb     = out_q.pRb;
    assign rn.out_pRc     = out_q.pRc;
    assign rn.out_pRt     = out_q.pRt;
    assign rn.out_pRtOld  = out_q.pRtOld;
    assign rn.out_aRt     = out_q.aRt;
    assign rn.out_has_dst = out_q.has_dst;

`ifdef QUPLS_RENAME_PERF_EN
    logic stall_ev;
    assign stall_ev = rn.in_v & dst & fl_empty & ~rn.flush;

    // Cycles lost to an empty free list, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_ev && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_qupls_rename_stage.sv
// Scoreboard bench for qupls_rename_stage against a queue-based model
// of free registers, uncommitted allocations and the two maps.
module tb_qupls_rename_stage;
    import qupls_rename_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qupls_rename_if rn ();

`ifdef QUPLS_RENAME_PERF_EN
    logic [31:0] stall_cnt;
`endif
    int m_stall;

    qupls_rename_stage dut (
        .clk (clk),
        .rst (rst),
`ifdef QUPLS_RENAME_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .rn  (rn)
    );

    typedef struct {
        logic [6:0] pra, prb, prc, prt, prto;
        logic [8:0] art;
        logic       hd;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       pend  [$];
    logic [6:0] free_q [$];
    logic [6:0] unc_q  [$];
    int         srat [64];
    int         crat [64];
    bit         mv;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        free_q.delete();
        unc_q.delete();
        mv = 0;
        m_stall = 0;
        for (int i = 0; i < 64; i++) begin
            srat[i] = i;
            crat[i] = i;
        end
        for (int i = 64; i < 128; i++)
            free_q.push_back(7'(i));
    endtask

    task automatic idle_inputs();
        rn.in_v = 0; rn.in_aRa = 0; rn.in_aRb = 0; rn.in_aRc = 0;
        rn.in_aRt = 0; rn.in_Raz = 1; rn.in_Rbz = 1; rn.in_Rcz = 1;
        rn.in_Rtz = 1; rn.out_rdy = 1; rn.cmt_v = 0; rn.cmt_has_dst = 0;
        rn.cmt_aRt = 0; rn.cmt_pRt = 0; rn.cmt_pRtOld = 0; rn.flush = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        #1;
        chk("rst_in_rdy", rn.in_rdy, 0);
        chk("rst_out_v", rn.out_v, 0);
        chk("rst_out_pRa", rn.out_pRa, 0);
        chk("rst_out_pRt", rn.out_pRt, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic step(
        input logic v,
        input logic [8:0] a, input logic [8:0] b,
        input logic [8:0] c, input logic [8:0] t,
        input logic za, input logic zb, input logic zc, input logic zt,
        input logic ordy, input logic cmt, input logic fl
    );
        exp_t e;
        exp_t p;
        bit erdy, acc, docmt;
        @(negedge clk);
        rn.in_v = v; rn.in_aRa = a; rn.in_aRb = b; rn.in_aRc = c;
        rn.in_aRt = t; rn.in_Raz = za; rn.in_Rbz = zb; rn.in_Rcz = zc;
        rn.in_Rtz = zt; rn.out_rdy = ordy; rn.flush = fl;
        docmt = cmt && pend.size() > 0;
        if (docmt) begin
            p = pend[0];
            rn.cmt_v = 1; rn.cmt_has_dst = p.hd; rn.cmt_aRt = p.art;
            rn.cmt_pRt = p.prt; rn.cmt_pRtOld = p.prto;
        end else begin
            rn.cmt_v = 0; rn.cmt_has_dst = 0; rn.cmt_aRt = 0;
            rn.cmt_pRt = 0; rn.cmt_pRtOld = 0;
        end
        #1;
        erdy = !fl && (!mv || ordy) && (zt || free_q.size() != 0);
        chk("in_rdy", rn.in_rdy, erdy);
        chk("out_v", rn.out_v, mv);
        if (v && !zt && free_q.size() == 0 && !fl)
            m_stall++;
        acc = v && erdy;
        if (acc) begin
            e.pra = za ? 7'd0 : 7'(srat[a[5:0]]);
            e.prb = zb ? 7'd0 : 7'(srat[b[5:0]]);
            e.prc = zc ? 7'd0 : 7'(srat[c[5:0]]);
            e.art = t;
            e.hd = !zt;
            e.prt = 0;
            e.prto = 0;
            if (!zt) begin
                e.prt = free_q.pop_front();
                e.prto = 7'(srat[t[5:0]]);
                srat[t[5:0]] = int'(e.prt);
                unc_q.push_back(e.prt);
            end
            exp_q.push_back(e);
            pend.push_back(e);
        end
        if (fl) begin
            if (mv && !ordy)
                void'(exp_q.pop_back());
            mv = 0;
        end else if (acc) begin
            mv = 1;
        end else if (ordy) begin
            mv = 0;
        end
        if (docmt) begin
            void'(pend.pop_front());
            if (p.hd) begin
                crat[p.art[5:0]] = int'(p.prt);
                void'(unc_q.pop_front());
                if (p.prto != 0)
                    free_q.push_back(p.prto);
            end
        end
        if (fl) begin
            free_q = {unc_q, free_q};
            unc_q.delete();
            pend.delete();
            srat = crat;
        end
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
    endtask

    task automatic dst_step(input logic [8:0] a, input logic [8:0] t,
                            input logic cmt);
        step(1, a, 0, 0, t, 0, 1, 1, 0, 1, cmt, 0);
    endtask

    task automatic rand_step();
        logic [8:0] a, b, c, t;
        logic zt;
        a = 9'($urandom_range(0, 511));
        b = 9'($urandom_range(0, 511));
        c = 9'($urandom_range(0, 511));
        zt = ($urandom % 4) == 0;
        if (zt)
            t = 9'($urandom_range(0, 511));
        else
            t = {3'($urandom_range(0, 7)), 6'($urandom_range(1, 63))};
        step(($urandom % 4) != 0, a, b, c, t,
             ($urandom % 8) == 0, ($urandom % 8) == 0,
             ($urandom % 8) == 0, zt,
             ($urandom % 4) != 0, ($urandom % 2) == 0,
             ($urandom % 64) == 0);
    endtask

    // Monitor: every transfer downstream is checked against the scoreboard
    initial begin
        exp_t e;
        bit ok;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && rn.out_v && rn.out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected pRa=%0d pRt=%0d",
                             rn.out_pRa, rn.out_pRt);
                end else begin
                    e = exp_q.pop_front();
                    ok = rn.out_pRa == e.pra && rn.out_pRb == e.prb
                      && rn.out_pRc == e.prc && rn.out_aRt == e.art
                      && rn.out_has_dst == e.hd;
                    if (e.hd)
                        ok = ok && rn.out_pRt == e.prt
                           && rn.out_pRtOld == e.prto;
                    if (!ok) begin
                        failures++;
                        $display("FAIL out_bundle got a/b/c=%0d/%0d/%0d t=%0d old=%0d art=%0d hd=%0d want a/b/c=%0d/%0d/%0d t=%0d old=%0d art=%0d hd=%0d",
                                 rn.out_pRa, rn.out_pRb, rn.out_pRc,
                                 rn.out_pRt, rn.out_pRtOld, rn.out_aRt,
                                 rn.out_has_dst, e.pra, e.prb, e.prc,
                                 e.prt, e.prto, e.art, e.hd);
                    end
                end
            end
        end
    end

    initial begin
        idle_inputs();
        model_reset();
        do_reset();

        // First rename after reset
        step(1, 5, 6, 0, 7, 0, 0, 1, 0, 1, 0, 0);
        idle_step();
        chk("t1_pRa", rn.out_pRa, 5);
        chk("t1_pRb", rn.out_pRb, 6);
        chk("t1_pRt", rn.out_pRt, 64);
        chk("t1_pRtOld", rn.out_pRtOld, 7);

        // Back-to-back writes to arch 3, second also reads arch 3
        do_reset();
        dst_step(0, 3, 0);
        dst_step(3, 3, 0);
        idle_step();
        chk("t2_pRa", rn.out_pRa, 64);
        chk("t2_pRt", rn.out_pRt, 65);
        chk("t2_pRtOld", rn.out_pRtOld, 64);

        // Drain the free list, then free arch 9's old register
        do_reset();
        dst_step(0, 9, 0);
        for (int i = 0; i < 63; i++)
            dst_step(0, 9'($urandom_range(1, 63)), 0);
        dst_step(0, 10, 1);
        chk("t3_full_rdy", rn.in_rdy, 0);
        dst_step(0, 10, 0);
        idle_step();
        chk("t3_pRt", rn.out_pRt, 9);

        // Downstream stall holds the output
        do_reset();
        dst_step(0, 20, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 21, 1, 1, 1, 0, 0, 0, 0);
            chk("t4_hold_pRt", rn.out_pRt, 64);
            chk("t4_hold_rdy", rn.in_rdy, 0);
        end
        dst_step(0, 21, 0);
        idle_step();

        // Allocate 4, commit 2, flush
        do_reset();
        for (int i = 11; i < 15; i++)
            dst_step(0, 9'(i), 0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1);
        dst_step(13, 15, 0);
        idle_step();
        chk("t5_pRt", rn.out_pRt, 66);
        chk("t5_pRa", rn.out_pRa, 13);

        // Zero operands and no destination
        do_reset();
        step(1, 5, 6, 7, 8, 1, 0, 0, 1, 1, 0, 0);
        idle_step();
        chk("t6_pRa", rn.out_pRa, 0);
        chk("t6_pRb", rn.out_pRb, 6);
        chk("t6_has_dst", rn.out_has_dst, 0);
        dst_step(0, 4, 0);
        idle_step();
        chk("t6_pRt", rn.out_pRt, 64);

        // Random traffic with a mid-run reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500)
                do_reset();
            rand_step();
        end

        for (int i = 0; i < 4; i++)
            idle_step();
        chk("drain_left", exp_q.size(), 0);
`ifdef QUPLS_RENAME_PERF_EN
        chk("stall_cnt", int'(stall_cnt), m_stall);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qupls_rename_stage.md
Name: qupls_rename_stage

Overview:
- Register-rename stage directly downstream of the operand decoders (Ra/Rb/Rc/Rt decode).
- Takes one decoded instruction per cycle, carrying architectural register numbers (aregno_t) and zero flags. Maps sources through a speculative register alias table (RAT) and allocates a physical destination from a circular free list.
- Commit returns old physical registers and advances a committed RAT.
- Flush restores the speculative state from the committed state.

Parameters:
- AREGS, 64, number of architectural registers renamed (low log2(AREGS) bits of aregno_t used).
- PREGS, 128, number of physical registers; must be a power of two and greater than AREGS.
- FL_DEPTH, PREGS-AREGS, free-list capacity in entries.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_v  in  1  decoded instruction valid.
- in_rdy  out  1  stage can accept this cycle.
- in_aRa, in_aRb, in_aRc, in_aRt  in  9 each  architectural source and destination numbers (aregno_t).
- in_Raz, in_Rbz, in_Rcz, in_Rtz  in  1 each  operand or destination is register zero.
- out_v  out  1  renamed instruction valid.
- out_rdy  in  1  downstream accepts.
- out_pRa, out_pRb, out_pRc  out  log2(PREGS) each  physical sources.
- out_pRt  out  log2(PREGS)  allocated physical destination.
- out_pRtOld  out  log2(PREGS)  previous mapping of aRt.
- out_aRt  out  9  architectural destination, passed through.
- out_has_dst  out  1  ~in_Rtz, registered.
- cmt_v  in  1  commit of one instruction.
- cmt_has_dst  in  1  committed instruction had a destination.
- cmt_aRt  in  9  committed architectural destination.
- cmt_pRt  in  log2(PREGS)  committed physical destination.
- cmt_pRtOld  in  log2(PREGS)  physical register to free.
- flush  in  1  pipeline flush to committed state.

Behaviour:
- Reset (async, rst=1):
  - Both RATs are identity (arch i maps to phys i).
  - Free list holds AREGS..PREGS-1 in order; alloc_head = commit_head = 0; tail = FL_DEPTH; count = FL_DEPTH.
  - out_v=0. All out_* data = 0.
  - in_rdy = 0 while rst is asserted.
- Handshake:
  - in_rdy = ~out_v | out_rdy, and additionally count≠0 when ~in_Rtz.
  - Accept when in_v & in_rdy. One-cycle latency: the output register loads on accept.
  - out_v clears when out_rdy & ~accept.
  - Output holds stable while out_v & ~out_rdy.
- Rename on accept:
  - Sources read the speculative RAT, bypassing an update from the prior accept (RAT is written at the clock edge, so this is a plain read).
  - A source with its z flag set yields phys 0.
  - If ~in_Rtz: pRt = freelist[alloc_head], pRtOld = specRAT[aRt], specRAT[aRt] := pRt, alloc_head++.
  - A source equal to aRt in the same instruction reads the old mapping.
  - Arch 0 is never written and never allocated.
- Commit (cmt_v):
  - If cmt_has_dst and cmt_pRtOld≠0: freelist[tail] := cmt_pRtOld, tail++.
  - If cmt_has_dst: commitRAT[cmt_aRt] := cmt_pRt, commit_head++.
  - Commit is independent of the input handshake.
- Count: count = tail - alloc_head, with pointers one bit wider than log2(FL_DEPTH) so wrap is unambiguous.
- Simultaneous accept and commit: both apply. A register freed this cycle is not allocatable until the next cycle.
- Flush (priority over accept; commit in the same cycle still applies):
  - alloc_head := commit_head (plus 1 if the same-cycle commit has_dst).
  - specRAT := commitRAT, including the same-cycle commit write.
  - out_v := 0. in_rdy = 0 that cycle.
- Overflow (count==FL_DEPTH with a push) is a protocol error: assertion in simulation; the push is dropped.
- Reset mid-operation returns everything to the reset state immediately.

Optional Feature:
- Macro: QUPLS_RENAME_PERF_EN.
- With the macro:
  - Output port stall_cnt (32 bits): counts cycles where in_v & ~in_rdy caused by count==0.
  - Saturates at all-ones; clears on rst.
- Without the macro: no port and no counter logic.

Decomposition:
- QuplsPkg gains:
  - pregno_t (log2(PREGS) bits).
  - Constants AREGS and PREGS.
  - rename_out_t struct bundling the out_* fields.
- aregno_t is reused.
- One sub-module, qupls_rename_freelist: circular buffer with alloc_head, commit_head, tail, count, and flush restore.
- The RAT pair stays in the top module.

Test Plan:
- Reset, then in_aRa=5, in_aRb=6, in_aRt=7 accepted → next cycle out_pRa=5, out_pRb=6, out_pRt=64, out_pRtOld=7.
- Back-to-back writes to aRt=3, then a read of aRa=3 → first pRt=64, second instruction out_pRa=64 and its pRt=65, pRtOld=64.
- 64 consecutive destination allocations with no commit → 65th has in_rdy=0. A commit with cmt_pRtOld=9 that cycle → accepted next cycle with pRt=9.
- out_rdy=0 for 3 cycles with out_v=1 → out_* stable; in_rdy=0 until out_rdy=1.
- Allocate 4 (pRt 64..67), commit first 2, flush → next allocation gets pRt=66; renaming the aRt of instruction 3 returns commitRAT's value.
- Zero operands: in_Rtz=1, in_Raz=1 → out_pRa=0, out_has_dst=0, free-list count unchanged; with the PERF macro, stall_cnt increments only on empty-list stalls.
